// File: rtl/usb_in_pkg.sv
// usb_in_pkg
//   Shared definitions for the USB IN-endpoint arbiter: FSM state encoding,
//   token endpoint-number width, default parameter values and a helper that
//   returns a safe counter/index width.
package usb_in_pkg;

  localparam int EP_W            = 4;     // width of the endpoint field in an IN token
  localparam int DEF_NUM_EP      = 3;
  localparam int DEF_ACK_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  // $clog2 returns 0 for n <= 1; never let a vector collapse to zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_in_ack_timer.sv
// usb_in_ack_timer
//   Counts clock cycles spent waiting for the host handshake.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : force the count to zero (takes priority over enable)
//     enable     : count one per cycle, holding at the terminal value
//     expired    : high while enabled and the count sits at ACK_TIMEOUT-1
module usb_in_ack_timer
  import usb_in_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = cnt_width(ACK_TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // The count parks at TERM instead of wrapping, so a missed expiry can
  // never turn into a second full timeout window.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TERM)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expired = enable && !clear && (count_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter
//   Routes IN tokens from the USB packet engine to one of NUM_EP endpoint
//   sources (endpoints 1..NUM_EP), forwards the selected source's byte stream
//   to the engine and returns the host handshake / error to that source.
//   Ports:
//     Clk, nReset                  : clock, asynchronous active-low reset
//     Token_Valid/Token_Endpoint   : IN token pulse and its endpoint number
//     Error                        : engine error pulse (abandons the packet)
//     Eng_*  (out)                 : byte stream muxed from the selected source
//     Eng_WaitRequest, Eng_Ack     : engine back-pressure and host ACK
//     Eng_Nak, Eng_Stall           : registered one-cycle NAK / STALL requests
//     Src_* (in)                   : per-endpoint streams, bit/byte i = endpoint i+1
//     Src_WaitRequest/Ack/Error    : per-endpoint back-pressure and completion pulses
//     Drop_Count                   : saturating count of tokens seen while busy
module usb_in_arbiter
  import usb_in_pkg::*;
#(
  parameter int NUM_EP      = DEF_NUM_EP,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                Token_Valid,
  input  logic [EP_W-1:0]     Token_Endpoint,
  input  logic                Error,
  output logic                Eng_Sequence,
  output logic                Eng_Ready,
  output logic                Eng_ZeroLength,
  output logic                Eng_Isochronous,
  output logic [7:0]          Eng_Data,
  input  logic                Eng_WaitRequest,
  input  logic                Eng_Ack,
  output logic                Eng_Nak,
  output logic                Eng_Stall,
  input  logic [NUM_EP-1:0]   Src_Sequence,
  input  logic [NUM_EP-1:0]   Src_Ready,
  input  logic [NUM_EP-1:0]   Src_ZeroLength,
  input  logic [NUM_EP-1:0]   Src_Isochronous,
  input  logic [8*NUM_EP-1:0] Src_Data,
  output logic [NUM_EP-1:0]   Src_WaitRequest,
  output logic [NUM_EP-1:0]   Src_Ack,
  output logic [NUM_EP-1:0]   Src_Error,
  output logic [7:0]          Drop_Count
);

  localparam int SEL_W = cnt_width(NUM_EP);

  // Reset asserts immediately but releases two clocks later, so no flop
  // leaves reset on a different edge than its neighbours.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               eng_nak_q, eng_nak_d;
  logic               eng_stall_q, eng_stall_d;
  logic [NUM_EP-1:0]  src_ack_q, src_ack_d;
  logic [NUM_EP-1:0]  src_error_q, src_error_d;
  logic [7:0]         drop_q, drop_d;

  logic               timer_clear, timer_enable, timer_expired;
  logic               tok_ep_valid;
  logic [SEL_W-1:0]   tok_idx;
  logic [NUM_EP-1:0]  sel_onehot;
  logic [7:0]         src_byte [NUM_EP];

  // Per-endpoint byte lanes, the one-hot form of Sel, and back-pressure:
  // only the selected source in DATA sees the engine's wait request.
  for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep
    assign src_byte[gi]        = Src_Data[8*gi +: 8];
    assign sel_onehot[gi]      = (sel_q == SEL_W'(gi));
    assign Src_WaitRequest[gi] = !((state_q == ST_DATA) && sel_onehot[gi]) || Eng_WaitRequest;
  end

  // Endpoint 0 (control) and anything beyond NUM_EP are not IN sources here.
  assign tok_ep_valid = (Token_Endpoint != '0) && (32'(Token_Endpoint) <= NUM_EP);
  assign tok_idx      = SEL_W'(Token_Endpoint - EP_W'(1));
  assign timer_enable = (state_q == ST_WAIT_ACK);

  usb_in_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (Clk),
    .rst_n   (rst_n_int),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_clear = 1'b0;
    eng_nak_d   = 1'b0;
    eng_stall_d = 1'b0;
    src_ack_d   = '0;
    src_error_d = '0;
    drop_d      = drop_q;

    // A token arriving on the very cycle we return to IDLE is still "busy"
    // because the decision uses the current state, so it is dropped too.
    if (Token_Valid && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (Token_Valid) begin
          if (!tok_ep_valid) begin
            eng_stall_d = 1'b1;
          end else if (Src_Ready[tok_idx]) begin
            sel_d   = tok_idx;
            state_d = ST_DATA;
          end else begin
            eng_nak_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (Error) begin
          src_error_d = sel_onehot;
          state_d     = ST_IDLE;
        end else if (!Src_Ready[sel_q]) begin
          timer_clear = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Error beats Ack; an Ack beats a timeout landing on the same cycle.
        if (Error) begin
          src_error_d = sel_onehot;
          state_d     = ST_IDLE;
        end else if (Eng_Ack) begin
          src_ack_d = sel_onehot;
          state_d   = ST_IDLE;
        end else if (timer_expired) begin
          src_error_d = sel_onehot;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      eng_nak_q   <= 1'b0;
      eng_stall_q <= 1'b0;
      src_ack_q   <= '0;
      src_error_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      eng_nak_q   <= eng_nak_d;
      eng_stall_q <= eng_stall_d;
      src_ack_q   <= src_ack_d;
      src_error_q <= src_error_d;
      drop_q      <= drop_d;
    end
  end

  // Zero-latency forwarding of the selected source while a packet is open.
  always_comb begin
    Eng_Data        = '0;
    Eng_Ready       = 1'b0;
    Eng_Sequence    = 1'b0;
    Eng_ZeroLength  = 1'b0;
    Eng_Isochronous = 1'b0;
    if (state_q != ST_IDLE) begin
      Eng_Data        = src_byte[sel_q];
      Eng_Ready       = Src_Ready[sel_q];
      Eng_Sequence    = Src_Sequence[sel_q];
      Eng_ZeroLength  = Src_ZeroLength[sel_q];
      Eng_Isochronous = Src_Isochronous[sel_q];
    end
  end

  assign Eng_Nak    = eng_nak_q;
  assign Eng_Stall  = eng_stall_q;
  assign Src_Ack    = src_ack_q;
  assign Src_Error  = src_error_q;
  assign Drop_Count = drop_q;

endmodule

// File: tb/tb_usb_in_arbiter.sv
module tb_usb_in_arbiter;

  localparam int NEP = 3;
  localparam int TMO = 16;

  logic        Clk = 1'b0;
  logic        nReset = 1'b1;
  logic        Token_Valid = 1'b0;
  logic [3:0]  Token_Endpoint = 4'd0;
  logic        Error = 1'b0;
  logic        Eng_Sequence, Eng_Ready, Eng_ZeroLength, Eng_Isochronous;
  logic [7:0]  Eng_Data;
  logic        Eng_WaitRequest = 1'b0;
  logic        Eng_Ack = 1'b0;
  logic        Eng_Nak, Eng_Stall;
  logic [2:0]  Src_Sequence = '0, Src_Ready = '0, Src_ZeroLength = '0, Src_Isochronous = '0;
  logic [23:0] Src_Data = '0;
  logic [2:0]  Src_WaitRequest, Src_Ack, Src_Error;
  logic [7:0]  Drop_Count;

  int checks = 0;
  int errors = 0;
  int drop_exp = 0;   // reference model: tokens seen while a packet is open

  usb_in_arbiter #(.NUM_EP(NEP), .ACK_TIMEOUT(TMO)) dut (
    .Clk(Clk), .nReset(nReset),
    .Token_Valid(Token_Valid), .Token_Endpoint(Token_Endpoint), .Error(Error),
    .Eng_Sequence(Eng_Sequence), .Eng_Ready(Eng_Ready), .Eng_ZeroLength(Eng_ZeroLength),
    .Eng_Isochronous(Eng_Isochronous), .Eng_Data(Eng_Data),
    .Eng_WaitRequest(Eng_WaitRequest), .Eng_Ack(Eng_Ack),
    .Eng_Nak(Eng_Nak), .Eng_Stall(Eng_Stall),
    .Src_Sequence(Src_Sequence), .Src_Ready(Src_Ready), .Src_ZeroLength(Src_ZeroLength),
    .Src_Isochronous(Src_Isochronous), .Src_Data(Src_Data),
    .Src_WaitRequest(Src_WaitRequest), .Src_Ack(Src_Ack), .Src_Error(Src_Error),
    .Drop_Count(Drop_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Maybe present a token while the arbiter is busy; the model counts it.
  task automatic busy_token(input int pct);
    Token_Valid    = ($urandom_range(99) < pct);
    Token_Endpoint = 4'($urandom_range(15));
    if (Token_Valid && drop_exp < 255) drop_exp++;
  endtask

  task automatic send_token(input int ep);
    Token_Valid    = 1'b1;
    Token_Endpoint = 4'(ep);
    tick();
    Token_Valid    = 1'b0;
  endtask

  // Token while idle that must be refused: STALL for a non-IN endpoint,
  // NAK for an IN endpoint whose source has nothing ready.
  task automatic idle_token(input int ep);
    logic stall_e, nak_e;
    stall_e = (ep == 0) || (ep > NEP);
    nak_e   = !stall_e && !Src_Ready[ep-1];
    send_token(ep);
    check("refuse_nak", Eng_Nak, nak_e);
    check("refuse_stall", Eng_Stall, stall_e);
    check("refuse_ready", Eng_Ready, 0);
    tick();
    check("refuse_pulse", {Eng_Nak, Eng_Stall}, 0);
    check("refuse_idle_wreq", Src_WaitRequest, 3'b111);
    $display("token ep=%0d nak=%0d stall=%0d", ep, nak_e, stall_e);
  endtask

  // One complete IN packet. mode: 0 ack, 1 error in WAIT_ACK,
  // 2 ack+error together, 3 timeout, 4 error during the data phase.
  task automatic run_packet(input int ep, input logic [7:0] q[$], input int wr_pct, input int mode);
    logic [2:0] onehot, wr_exp;
    logic       seq, zlp, iso;
    int idx, cyc, n, w, stop_at;
    onehot = '0;
    onehot[ep-1] = 1'b1;
    Src_Ready       = 3'($urandom);
    Src_Data        = 24'($urandom);
    Src_Sequence    = 3'($urandom);
    Src_ZeroLength  = 3'($urandom);
    Src_Isochronous = 3'($urandom);
    seq = Src_Sequence[ep-1];
    zlp = Src_ZeroLength[ep-1];
    iso = Src_Isochronous[ep-1];
    Src_Ready[ep-1] = 1'b1;
    Src_Data[(ep-1)*8 +: 8] = q[0];
    send_token(ep);
    check("tok_no_refuse", {Eng_Nak, Eng_Stall}, 0);
    idx = 0;
    cyc = 0;
    stop_at = (mode == 4) ? q.size() / 2 : q.size();
    while (idx < stop_at && cyc < 500) begin
      Eng_WaitRequest = ($urandom_range(99) < wr_pct);
      busy_token(20);
      #1;
      wr_exp = 3'b111;
      wr_exp[ep-1] = Eng_WaitRequest;
      check("eng_data", Eng_Data, q[idx]);
      check("eng_flags", {Eng_Ready, Eng_Sequence, Eng_ZeroLength, Eng_Isochronous}, {1'b1, seq, zlp, iso});
      check("src_waitreq", Src_WaitRequest, wr_exp);
      @(posedge Clk);
      #1;
      if (!Eng_WaitRequest) begin
        idx++;
        if (idx < q.size()) Src_Data[(ep-1)*8 +: 8] = q[idx];
      end
      cyc++;
    end
    Token_Valid = 1'b0;
    Eng_WaitRequest = 1'b0;
    if (cyc >= 500) check("data_bound", 0, 1);
    if (mode == 4) begin
      Error = 1'b1;
      busy_token(50);
      tick();
      Error = 1'b0;
      Token_Valid = 1'b0;
      Src_Ready[ep-1] = 1'b0;
      check("data_err", Src_Error, onehot);
      check("data_err_noack", Src_Ack, 0);
    end else begin
      Src_Ready[ep-1] = 1'b0;
      busy_token(20);
      tick();
      Token_Valid = 1'b0;
      check("wait_ready", Eng_Ready, 0);
      check("wait_wreq", Src_WaitRequest, 3'b111);
      if (mode == 3) begin
        n = 0;
        while (Src_Error == 3'b000 && n < 40) begin
          busy_token(20);
          tick();
          Token_Valid = 1'b0;
          n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_err", Src_Error, onehot);
        check("tmo_noack", Src_Ack, 0);
      end else begin
        w = $urandom_range(0, 10);
        for (int i = 0; i < w; i++) begin
          busy_token(20);
          tick();
          Token_Valid = 1'b0;
          check("wait_quiet", {Src_Ack, Src_Error}, 0);
        end
        Eng_Ack = (mode != 1);
        Error   = (mode != 0);
        busy_token(50);
        tick();
        Eng_Ack = 1'b0;
        Error = 1'b0;
        Token_Valid = 1'b0;
        check("end_ack", Src_Ack, (mode == 0) ? onehot : 3'b000);
        check("end_err", Src_Error, (mode == 0) ? 3'b000 : onehot);
      end
    end
    check("drop_count", Drop_Count, drop_exp);
    check("drop_not_served", {Eng_Nak, Eng_Stall}, 0);
    tick();
    check("pulse_one_cycle", {Src_Ack, Src_Error}, 0);
    check("idle_ready", Eng_Ready, 0);
    check("idle_data", Eng_Data, 0);
    $display("packet ep=%0d bytes=%0d mode=%0d drops=%0d", ep, q.size(), mode, drop_exp);
  endtask

  initial begin
    logic [7:0] q[$];
    int ep;

    // Reset state
    #1 nReset = 1'b0;
    tick();
    tick();
    check("rst_wreq", Src_WaitRequest, 3'b111);
    check("rst_pulses", {Eng_Nak, Eng_Stall, Src_Ack, Src_Error}, 0);
    check("rst_drop", Drop_Count, 0);
    check("rst_eng", {Eng_Ready, Eng_Data}, 0);
    nReset = 1'b1;
    repeat (3) tick();

    // EP2, bytes 01 05 00, no back-pressure, then ACK
    q = '{8'h01, 8'h05, 8'h00};
    run_packet(2, q, 0, 0);

    // Refused tokens: NAK on empty EP3, STALL on EP0 / EP5 / EP4 / EP15
    Src_Ready = 3'b011;
    idle_token(3);
    idle_token(0);
    idle_token(5);
    idle_token(4);
    idle_token(15);

    // EP1 timeout, ACK+Error collision
    q = '{8'hA5, 8'h3C};
    run_packet(1, q, 30, 3);
    q = '{8'h77};
    run_packet(3, q, 0, 2);

    // Randomised packets interleaved with refused tokens
    for (int k = 0; k < 20; k++) begin
      q.delete();
      for (int i = 0, nb = $urandom_range(1, 6); i < nb; i++) q.push_back(8'($urandom));
      run_packet($urandom_range(1, NEP), q, $urandom_range(0, 60), $urandom_range(0, 4));
      Src_Ready = 3'($urandom);
      ep = $urandom_range(0, 15);
      if (ep >= 1 && ep <= NEP) Src_Ready[ep-1] = 1'b0;
      idle_token(ep);
    end

    // 300 tokens while busy saturate the drop counter
    Src_Ready = 3'b001;
    send_token(1);
    Eng_WaitRequest = 1'b1;
    for (int i = 0; i < 300; i++) begin
      Token_Valid = 1'b1;
      Token_Endpoint = 4'($urandom_range(15));
      tick();
    end
    Token_Valid = 1'b0;
    Eng_WaitRequest = 1'b0;
    check("drop_saturate", Drop_Count, 8'd255);
    Src_Ready = 3'b000;
    tick();
    Eng_Ack = 1'b1;
    tick();
    Eng_Ack = 1'b0;
    check("sat_pkt_ack", Src_Ack, 3'b001);
    $display("packet ep=1 drops=300 drop_count=%0d", Drop_Count);

    // Reset in the middle of an EP2 data phase
    Src_Ready = 3'b010;
    Src_Data = 24'h00_99_00;
    send_token(2);
    check("pre_rst_data", Eng_Data, 8'h99);
    nReset = 1'b0;
    #1;
    check("mid_rst_wreq", Src_WaitRequest, 3'b111);
    check("mid_rst_eng", {Eng_Ready, Eng_Data}, 0);
    check("mid_rst_pulses", {Eng_Nak, Eng_Stall, Src_Ack, Src_Error}, 0);
    check("mid_rst_drop", Drop_Count, 0);
    drop_exp = 0;
    tick();
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", {Src_Ack, Src_Error}, 0);
    end
    $display("reset during ep=2 data phase");
    q = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_packet(2, q, 25, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
